// File: rtl/sysid_pkg.sv
// Purpose: shared register map, CAPS field layout and CAPS word builder for sysid_uptime.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package sysid_pkg;

    // Word addresses on the 3-bit register bus.
    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADDR_CAPS      = 3'd5;
    localparam logic [2:0] ADDR_CONTROL   = 3'd6;

    // CAPS layout: {prescale[23:0], 4'b0, read_latency[3:0]}.
    localparam int CAPS_LAT_LSB      = 0;
    localparam int CAPS_LAT_W        = 4;
    localparam int CAPS_PRESCALE_LSB = 8;
    localparam int CAPS_PRESCALE_W   = 24;

    // CONTROL bit that clears the uptime counter and prescaler.
    localparam int CONTROL_CLEAR_BIT = 0;

    function automatic logic [31:0] caps_word(input logic [23:0] prescale,
                                              input logic [3:0]  latency);
        logic [31:0] w;
        w = '0;
        w[CAPS_PRESCALE_LSB +: CAPS_PRESCALE_W] = prescale;
        w[CAPS_LAT_LSB +: CAPS_LAT_W]           = latency;
        return w;
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Purpose: free-running prescaler feeding a 64-bit uptime counter, with synchronous clear.
// Latency: count reflects a tick or clear on the clock edge that applies it.
// Backpressure: none; counts every cycle.
//
// Ports: clock, reset_n (async active-low), clear (sync, wins over a tick),
//        count[63:0] (current uptime in ticks).
module sysid_uptime_ctr #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    output logic [63:0] count
);

    logic [23:0] pre_q;
    logic [63:0] count_q;
    logic        tick;

    // The tick coincides with the edge on which the prescaler wraps back to 0.
    assign tick = (pre_q == 24'(PRESCALE - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            pre_q <= tick ? 24'd0 : pre_q + 24'd1;
            if (tick) begin
                count_q <= count_q + 64'd1;
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sysid_uptime.sv
// Purpose: system ID / build timestamp / uptime register block on a simple read/write bus.
// Latency: read data returned READ_LATENCY cycles after accept, pipelined one per cycle.
// Backpressure: none; every read and write is accepted the cycle it is presented.
//
// Ports: clock, reset_n (async active-low), address[2:0], read, write,
//        writedata[31:0], byteenable[3:0], readdata[31:0] (zero unless valid),
//        readdatavalid (one pulse per accepted read).
module sysid_uptime
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned PRESCALE     = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] CAPS = caps_word(24'(PRESCALE), 4'(READ_LATENCY));

    logic [63:0] uptime;
    logic [31:0] shadow_hi;
    logic [31:0] scratch;
    logic [31:0] rd_dat;
    logic        clear;

    logic [READ_LATENCY-1:0]       pipe_vld;
    logic [READ_LATENCY-1:0][31:0] pipe_dat;

    assign clear = write && (address == ADDR_CONTROL) && writedata[CONTROL_CLEAR_BIT];

    sysid_uptime_ctr #(
        .PRESCALE (PRESCALE)
    ) u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .count   (uptime)
    );

    // Read mux samples state before any same-cycle write lands.
    always_comb begin
        rd_dat = '0;
        case (address)
            ADDR_ID:        rd_dat = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_dat = TIMESTAMP;
            ADDR_UPTIME_LO: rd_dat = uptime[31:0];
            ADDR_UPTIME_HI: rd_dat = shadow_hi;
            ADDR_SCRATCH:   rd_dat = scratch;
            ADDR_CAPS:      rd_dat = CAPS;
            default:        rd_dat = '0;
        endcase
    end

    // Reading LO freezes the matching HI word so a LO-then-HI pair is coherent
    // even if the counter carries between the two reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_hi <= '0;
        end else if (read && (address == ADDR_UPTIME_LO)) begin
            shadow_hi <= uptime[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
        end else if (write && (address == ADDR_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // Shift-register read pipeline; data is zeroed in empty slots so the
    // output stays 0 whenever no result is being delivered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            pipe_dat <= '0;
        end else begin
            pipe_vld[0] <= read;
            pipe_dat[0] <= read ? rd_dat : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign readdatavalid = pipe_vld[READ_LATENCY-1];
    assign readdata      = pipe_vld[READ_LATENCY-1] ? pipe_dat[READ_LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_sysid_uptime.sv
// Purpose: self-checking bench for sysid_uptime (latency-1 and latency-3 instances on one bus).
// Latency: n/a.
// Backpressure: n/a.
module tb_sysid_uptime;

    localparam logic [31:0] SYS_ID = 32'hC0FF_EE01;
    localparam logic [31:0] TS     = 32'h6650_1234;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata1;
    logic        rvld1;
    logic [31:0] rdata3;
    logic        rvld3;

    int checks = 0;
    int errors = 0;

    sysid_uptime #(
        .SYSTEM_ID    (SYS_ID),
        .TIMESTAMP    (TS),
        .READ_LATENCY (1),
        .PRESCALE     (4)
    ) dut1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rdata1),
        .readdatavalid (rvld1)
    );

    sysid_uptime #(
        .SYSTEM_ID    (SYS_ID),
        .TIMESTAMP    (TS),
        .READ_LATENCY (3),
        .PRESCALE     (4)
    ) dut3 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (rdata3),
        .readdatavalid (rvld3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] wdat;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge,
    // where the latency-1 instance must present the result.
    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        check({name, " vld"}, {63'd0, rvld1}, 64'd1);
        check(name, {32'd0, rdata1}, {32'd0, exp});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clock);
        write      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_dat [8];
        logic        exp_vld [8];
        logic [2:0]  pl_addr [4];
        int          seen;

        reset_n    = 1'b0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;

        // Directed register-map vectors for the latency-1 instance.
        vecs.push_back('{1'b0, 3'd0, 32'h0,          4'h0, SYS_ID});
        vecs.push_back('{1'b0, 3'd1, 32'h0,          4'h0, TS});
        vecs.push_back('{1'b0, 3'd5, 32'h0,          4'h0, 32'h0000_0401});
        vecs.push_back('{1'b0, 3'd6, 32'h0,          4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd7, 32'h0,          4'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,          4'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'hAABB_CCDD,  4'hF, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,          4'h0, 32'hAABB_CCDD});
        vecs.push_back('{1'b1, 3'd4, 32'h1122_3344,  4'h5, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,          4'h0, 32'hAA22_CC44});
        vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF,  4'hF, 32'h0});
        vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF,  4'hF, 32'h0});
        vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF,  4'hF, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h0,          4'h0, SYS_ID});
        vecs.push_back('{1'b0, 3'd5, 32'h0,          4'h0, 32'h0000_0401});
        vecs.push_back('{1'b1, 3'd4, 32'h9900_0000,  4'h8, 32'h0});
        vecs.push_back('{1'b0, 3'd4, 32'h0,          4'h0, 32'h9922_CC44});
        vecs.push_back('{1'b1, 3'd3, 32'h1234_5678,  4'hF, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h0,          4'h0, 32'h0});

        // Reset state.
        #1;
        check("reset vld1",  {63'd0, rvld1}, 64'd0);
        check("reset data1", {32'd0, rdata1}, 64'd0);
        check("reset vld3",  {63'd0, rvld3}, 64'd0);
        check("reset data3", {32'd0, rdata3}, 64'd0);
        @(negedge clock);
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].wdat, vecs[i].be);
            end else begin
                bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
            end
        end

        @(negedge clock);
        check("idle vld1",  {63'd0, rvld1}, 64'd0);
        check("idle data1", {32'd0, rdata1}, 64'd0);

        // Same-cycle read and write: read sees the old value.
        address    = 3'd4;
        writedata  = 32'h1234_5678;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        check("rw old value", {32'd0, rdata1}, 64'h9922_CC44);
        bus_read(3'd4, 32'h1234_5678, "rw new value");

        // Latency-3 pipeline: four back-to-back reads.
        repeat (4) @(negedge clock);
        pl_addr = '{3'd0, 3'd4, 3'd5, 3'd7};
        exp_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_dat = '{32'h0, 32'h0, SYS_ID, 32'h1234_5678, 32'h0000_0403, 32'h0, 32'h0, 32'h0};
        for (int c = 0; c < 8; c++) begin
            read    = (c < 4);
            address = (c < 4) ? pl_addr[c] : 3'd0;
            @(negedge clock);
            check($sformatf("pipe vld c%0d", c), {63'd0, rvld3}, {63'd0, exp_vld[c]});
            check($sformatf("pipe dat c%0d", c), {32'd0, rdata3}, {32'd0, exp_dat[c]});
        end
        read = 1'b0;

        // Uptime after 40 idle cycles at PRESCALE=4, then clear behaviour.
        do_reset();
        repeat (40) @(negedge clock);
        bus_read(3'd2, 32'd10, "uptime 40 cycles");
        bus_write(3'd6, 32'h1, 4'hF);
        bus_read(3'd2, 32'd0, "uptime after clear");
        repeat (6) @(negedge clock);
        bus_write(3'd6, 32'h2, 4'hF);
        bus_read(3'd2, 32'd2, "control bit0 zero");
        repeat (2) @(negedge clock);
        bus_write(3'd6, 32'h1, 4'hF);
        bus_read(3'd2, 32'd0, "clear beats tick");

        // Carry into the high word and shadow coherence.
        do_reset();
        bus_write(3'd6, 32'h1, 4'hF);
        force dut1.u_ctr.count_q = 64'h0000_0000_FFFF_FFFF;
        release dut1.u_ctr.count_q;
        repeat (4) @(negedge clock);
        bus_read(3'd2, 32'h0, "carry lo");
        bus_read(3'd3, 32'h1, "carry hi");
        bus_read(3'd3, 32'h1, "carry hi again");

        // HI must come from the shadow, not the live counter.
        do_reset();
        force dut1.u_ctr.count_q = 64'h0000_0005_0000_0000;
        release dut1.u_ctr.count_q;
        bus_read(3'd3, 32'h0, "hi before lo");
        bus_read(3'd2, 32'h0, "lo snapshot");
        bus_read(3'd3, 32'h5, "hi after lo");

        // Reads in flight when reset hits are dropped.
        bus_write(3'd4, 32'hDEAD_BEEF, 4'hF);
        repeat (4) @(negedge clock);
        address = 3'd0;
        read    = 1'b1;
        repeat (2) @(negedge clock);
        read    = 1'b0;
        reset_n = 1'b0;
        #1;
        check("inflight reset vld3", {63'd0, rvld3}, 64'd0);
        check("inflight reset dat3", {32'd0, rdata3}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (rvld1 || rvld3) seen++;
        end
        check("no vld after reset", 64'(seen), 64'd0);
        bus_read(3'd4, 32'h0, "scratch after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
